// File: rtl/spu_ma_pkg.sv
// Shared constants for the SPU modular-arithmetic LSU request arbiter.
package spu_ma_pkg;

   localparam int SPU_MA_MAX_ST_OUTST = 4;
   localparam int SPU_MA_CNT_W        = 3;

   typedef enum logic {
      SPU_MA_REQ_LD = 1'b0,
      SPU_MA_REQ_ST = 1'b1
   } spu_ma_req_e;

endpackage

// File: rtl/spu_malsu_cntr.sv
// Saturating up/down counter; registered count, same-cycle inc+dec cancel.
// Underflow is a combinational flag raised when a lone dec arrives at zero.
module spu_malsu_cntr #(
   parameter int W   = 3,
   parameter int MAX = 4
) (
   input  logic         clk,
   input  logic         rst_l,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         underflow
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d     = cnt_q;
      underflow = 1'b0;
      if (inc && !dec) begin
         if (cnt_q != W'(MAX)) cnt_d = cnt_q + W'(1);
      end else if (dec && !inc) begin
         if (cnt_q == '0) underflow = 1'b1;
         else             cnt_d     = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/spu_malsu_arb.sv
// Round-robin share of the SPU->LSU port between MA load and store sequencers.
// Grant is combinational, LSU request 1 cycle later; stores capped, one load in flight, abort blocks grants.
module spu_malsu_arb
   import spu_ma_pkg::*;
#(
   parameter int MAX_ST_OUTST = SPU_MA_MAX_ST_OUTST,
   parameter int CNT_W        = SPU_MA_CNT_W
) (
   input  logic             rclk,
   input  logic             rst_l,
   input  logic             se,
   input  logic             mald_req,
   input  logic             mast_req,
   input  logic             ma_abort,
   input  logic             lsu_spu_ld_ack,
   input  logic             lsu_spu_st_ack,
   output logic             mald_gnt,
   output logic             mast_gnt,
   output logic             spu_lsu_ldreq,
   output logic             spu_lsu_streq,
   output logic [CNT_W-1:0] st_outst_cnt,
   output logic             ld_busy,
   output logic             all_drained,
   output logic             ack_err
);

   spu_ma_req_e      last_winner_q, last_winner_d;
   logic             ldreq_q, ldreq_d;
   logic             streq_q, streq_d;
   logic             ld_busy_q, ld_busy_d;
   logic             ack_err_q, ack_err_d;
   logic             ld_elig, st_elig, st_room;
   logic             st_underflow;
   logic [CNT_W:0]   st_eff;
   logic             unused_se;

   assign unused_se = se;

   // A store granted last cycle is not in the count yet, so reserve its slot here.
   assign st_eff  = {1'b0, st_outst_cnt} + {{CNT_W{1'b0}}, streq_q};
   assign st_room = (st_eff < (CNT_W+1)'(MAX_ST_OUTST));

   always_comb begin
      ld_elig  = mald_req & ~ld_busy_q & ~ma_abort & ~ldreq_q;
      st_elig  = mast_req & st_room & ~ma_abort;
      mald_gnt = rst_l & ld_elig & (~st_elig | (last_winner_q == SPU_MA_REQ_ST));
      mast_gnt = rst_l & st_elig & (~ld_elig | (last_winner_q == SPU_MA_REQ_LD));

      last_winner_d = last_winner_q;
      if (mald_gnt)      last_winner_d = SPU_MA_REQ_LD;
      else if (mast_gnt) last_winner_d = SPU_MA_REQ_ST;

      ldreq_d = mald_gnt;
      streq_d = mast_gnt;

      // An ack always wins over a same-cycle set; the error flag catches that case.
      ld_busy_d = ld_busy_q;
      if (lsu_spu_ld_ack) ld_busy_d = 1'b0;
      else if (ldreq_q)   ld_busy_d = 1'b1;

      ack_err_d = ack_err_q | (lsu_spu_ld_ack & ~ld_busy_q) | st_underflow;
   end

   always_ff @(posedge rclk) begin
      if (!rst_l) begin
         last_winner_q <= SPU_MA_REQ_ST;
         ldreq_q       <= 1'b0;
         streq_q       <= 1'b0;
         ld_busy_q     <= 1'b0;
         ack_err_q     <= 1'b0;
      end else begin
         last_winner_q <= last_winner_d;
         ldreq_q       <= ldreq_d;
         streq_q       <= streq_d;
         ld_busy_q     <= ld_busy_d;
         ack_err_q     <= ack_err_d;
      end
   end

   spu_malsu_cntr #(
      .W   (CNT_W),
      .MAX (MAX_ST_OUTST)
   ) u_st_cntr (
      .clk       (rclk),
      .rst_l     (rst_l),
      .inc       (streq_q),
      .dec       (lsu_spu_st_ack),
      .cnt       (st_outst_cnt),
      .underflow (st_underflow)
   );

   assign spu_lsu_ldreq = ldreq_q;
   assign spu_lsu_streq = streq_q;
   assign ld_busy       = ld_busy_q;
   assign ack_err       = ack_err_q;
   assign all_drained   = (st_outst_cnt == '0) & ~ld_busy_q & ~ldreq_q & ~streq_q;

endmodule

// File: tb/tb_spu_malsu_arb.sv
// Directed bench for spu_malsu_arb: per-cycle model comparison on the falling edge
// plus hand-computed expectations at key points of each scenario.
module tb_spu_malsu_arb;

   localparam int MAX = 4;
   localparam int CW  = 3;

   logic          rclk = 1'b0;
   logic          rst_l, se, mald_req, mast_req, ma_abort, ld_ack, st_ack;
   logic          mald_gnt, mast_gnt, ldreq, streq, ld_busy, all_drained, ack_err;
   logic [CW-1:0] cnt;

   int errs   = 0;
   int checks = 0;

   always #5 rclk = ~rclk;

   spu_malsu_arb #(.MAX_ST_OUTST(MAX), .CNT_W(CW)) dut (
      .rclk           (rclk),
      .rst_l          (rst_l),
      .se             (se),
      .mald_req       (mald_req),
      .mast_req       (mast_req),
      .ma_abort       (ma_abort),
      .lsu_spu_ld_ack (ld_ack),
      .lsu_spu_st_ack (st_ack),
      .mald_gnt       (mald_gnt),
      .mast_gnt       (mast_gnt),
      .spu_lsu_ldreq  (ldreq),
      .spu_lsu_streq  (streq),
      .st_outst_cnt   (cnt),
      .ld_busy        (ld_busy),
      .all_drained    (all_drained),
      .ack_err        (ack_err)
   );

   task automatic chk(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, want, $time);
      end
   endtask

   // Model state: stores on record at the LSU, load outstanding, pulses on the wire.
   bit m_valid = 1'b0;
   int m_st;
   bit m_ld, m_ldreq, m_streq, m_lw, m_err;
   bit gl, gs, lok, sok;

   always @(negedge rclk) begin
      lok = mald_req && !m_ld && !m_ldreq && !ma_abort;
      sok = mast_req && ((m_st + int'(m_streq)) < MAX) && !ma_abort;
      gl  = rst_l && lok && (!sok || m_lw);
      gs  = rst_l && sok && (!lok || !m_lw);
      if (m_valid) begin
         chk("m_mald_gnt", int'(mald_gnt), int'(gl));
         chk("m_mast_gnt", int'(mast_gnt), int'(gs));
         chk("m_ldreq", int'(ldreq), int'(m_ldreq));
         chk("m_streq", int'(streq), int'(m_streq));
         chk("m_st_cnt", int'(cnt), m_st);
         chk("m_ld_busy", int'(ld_busy), int'(m_ld));
         chk("m_drained", int'(all_drained),
             int'(m_st == 0 && !m_ld && !m_ldreq && !m_streq));
         chk("m_ack_err", int'(ack_err), int'(m_err));
      end
      if (!rst_l) begin
         m_valid = 1'b1;
         m_st = 0; m_ld = 0; m_ldreq = 0; m_streq = 0; m_lw = 1; m_err = 0;
      end else if (m_valid) begin
         if (ld_ack) begin
            if (!m_ld) m_err = 1;
            m_ld = 0;
         end else if (m_ldreq) begin
            m_ld = 1;
         end
         if (m_streq && !st_ack) m_st++;
         else if (st_ack && !m_streq) begin
            if (m_st == 0) m_err = 1;
            else           m_st--;
         end
         if (gl)      m_lw = 0;
         else if (gs) m_lw = 1;
         m_ldreq = gl;
         m_streq = gs;
      end
   end

   // LSU stand-in: when enabled, acks each request pulse in the following cycle.
   bit auto_ack = 1'b0;
   bit p_ld = 1'b0, p_st = 1'b0;

   task automatic step();
      @(posedge rclk);
      #1;
      if (auto_ack) begin
         ld_ack = p_ld;
         st_ack = p_st;
      end
      p_ld = ldreq;
      p_st = streq;
   endtask

   int pulses, nl, ns, ng;

   initial begin
      rst_l = 0; se = 0; mald_req = 0; mast_req = 0; ma_abort = 0; ld_ack = 0; st_ack = 0;

      // Reset state and grant suppression while in reset
      step();
      mald_req = 1; mast_req = 1; #1;
      chk("rst_mald_gnt", int'(mald_gnt), 0);
      chk("rst_mast_gnt", int'(mast_gnt), 0);
      step();
      mald_req = 0; mast_req = 0; #1;
      chk("rst_ldreq", int'(ldreq), 0);
      chk("rst_streq", int'(streq), 0);
      chk("rst_cnt", int'(cnt), 0);
      chk("rst_ld_busy", int'(ld_busy), 0);
      chk("rst_ack_err", int'(ack_err), 0);
      chk("rst_drained", int'(all_drained), 1);

      // First tie goes to load, store follows
      rst_l = 1; mald_req = 1; mast_req = 1; #1;
      chk("tie_mald_gnt", int'(mald_gnt), 1);
      chk("tie_mast_gnt", int'(mast_gnt), 0);
      step();
      mald_req = 0; #1;
      chk("t1_ldreq", int'(ldreq), 1);
      chk("t1_mast_gnt", int'(mast_gnt), 1);
      step();
      mast_req = 0; #1;
      chk("t1_streq", int'(streq), 1);
      chk("t1_ld_busy", int'(ld_busy), 1);
      step(); #1;
      chk("t1_cnt", int'(cnt), 1);
      chk("t1_not_drained", int'(all_drained), 0);
      ld_ack = 1; st_ack = 1;
      step();
      ld_ack = 0; st_ack = 0; #1;
      chk("t1_ld_busy_clr", int'(ld_busy), 0);
      chk("t1_drained", int'(all_drained), 1);

      // Store cap: held request, no acks
      mast_req = 1; pulses = 0;
      repeat (6) begin
         step();
         pulses += int'(streq);
      end
      #1;
      chk("cap_pulses", pulses, 4);
      chk("cap_cnt", int'(cnt), 4);
      chk("cap_no_gnt", int'(mast_gnt), 0);
      st_ack = 1;
      step();
      st_ack = 0; #1;
      chk("cap_cnt_after_ack", int'(cnt), 3);
      chk("cap_regrant", int'(mast_gnt), 1);
      step();
      mast_req = 0; #1;
      chk("cap_streq", int'(streq), 1);
      step(); #1;
      chk("cap_cnt_full", int'(cnt), 4);
      st_ack = 1;
      repeat (4) step();
      st_ack = 0; #1;
      chk("cap_cnt_empty", int'(cnt), 0);
      chk("cap_drained", int'(all_drained), 1);

      // Both held with immediate acks; a busy load lets the store win twice in a row
      auto_ack = 1; p_ld = 0; p_st = 0; mald_req = 1; mast_req = 1; nl = 0; ns = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         nl += int'(mald_gnt);
         ns += int'(mast_gnt);
         if (i > 0) chk("rr_busy", int'(all_drained), 0);
         step();
      end
      mald_req = 0; mast_req = 0;
      repeat (4) step();
      auto_ack = 0; ld_ack = 0; st_ack = 0; #1;
      chk("rr_ld_gnts", nl, 2);
      chk("rr_st_gnts", ns, 4);
      chk("rr_drained", int'(all_drained), 1);

      // Abort with three stores outstanding
      mast_req = 1;
      repeat (3) step();
      mast_req = 0;
      step(); step(); #1;
      chk("ab_cnt", int'(cnt), 3);
      ma_abort = 1; mast_req = 1; mald_req = 1; ng = 0;
      repeat (10) begin
         #1;
         ng += int'(mald_gnt) + int'(mast_gnt);
         step();
      end
      ma_abort = 0; mast_req = 0; mald_req = 0;
      chk("ab_no_gnt", ng, 0);
      st_ack = 1;
      repeat (3) step();
      st_ack = 0; #1;
      chk("ab_cnt_zero", int'(cnt), 0);
      chk("ab_drained", int'(all_drained), 1);
      chk("ab_ack_err", int'(ack_err), 0);

      // Spurious store ack
      st_ack = 1;
      step();
      st_ack = 0; #1;
      chk("ue_cnt", int'(cnt), 0);
      chk("ue_ack_err", int'(ack_err), 1);
      repeat (3) step();
      #1;
      chk("ue_sticky", int'(ack_err), 1);

      // Mid-operation reset with two stores and a load outstanding
      mald_req = 1; mast_req = 1;
      step();
      mald_req = 0;
      step(); step();
      mast_req = 0;
      step(); #1;
      chk("mr_cnt", int'(cnt), 2);
      chk("mr_ld_busy", int'(ld_busy), 1);
      rst_l = 0;
      step();
      rst_l = 1; #1;
      chk("mr_ldreq", int'(ldreq), 0);
      chk("mr_streq", int'(streq), 0);
      chk("mr_cnt0", int'(cnt), 0);
      chk("mr_ld_busy0", int'(ld_busy), 0);
      chk("mr_ack_err0", int'(ack_err), 0);
      chk("mr_drained", int'(all_drained), 1);
      mald_req = 1; mast_req = 1; #1;
      chk("mr_tie_ld", int'(mald_gnt), 1);
      chk("mr_tie_st", int'(mast_gnt), 0);
      step();
      mald_req = 0; mast_req = 0;
      step(); step();
      #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at t=%0t, expected finish before 100000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
